// File: rtl/btn_pkg.sv
// Shared constants, FSM state type and priority helper for the pushbutton move-code encoder.
package btn_pkg;

  localparam logic [3:0] DIR_U    = 4'b1000;
  localparam logic [3:0] DIR_D    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_L    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    DELAY,
    REPEAT,
    HOLD
  } state_t;

  // Fixed priority U > D > R > L; returns DIR_NONE when nothing is pressed.
  function automatic logic [3:0] prio_onehot(input logic [3:0] req);
    logic [3:0] win;
    win = DIR_NONE;
    if (req[3])      win = DIR_U;
    else if (req[2]) win = DIR_D;
    else if (req[1]) win = DIR_R;
    else if (req[0]) win = DIR_L;
    return win;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: two-flop synchroniser followed by a consecutive-sample debounce counter.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic btnClk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments make sync_q2 take the previous sync_q1, giving a true two-flop chain.
  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_move_encoder.sv
// Debounced, arbitrated one-hot move-code generator for the player blocks.
// Define BTN_AUTO_REPEAT_EN for held-button auto-repeat; otherwise one pulse per press.
module btn_move_encoder
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 3
) (
  input  logic       btnClk,
  input  logic       rst,
  input  logic [3:0] btns_raw,
  output logic [3:0] btns,
  output logic       move_valid,
  output logic [3:0] dir_held
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 1) begin : g_bad_param
    $error("btn_move_encoder: parameter out of range");
  end

  logic [3:0] deb;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .btnClk(btnClk),
      .rst   (rst),
      .raw   (btns_raw[i]),
      .level (deb[i])
    );
  end

  logic [3:0] winner;
  logic       held_pressed;

  assign winner       = prio_onehot(deb);
  assign held_pressed = |(deb & dir_held);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] DELAY_LOAD = CW'(REPEAT_DELAY - 2);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(REPEAT_RATE - 1);

  logic [CW-1:0] cnt;
`endif

  state_t state;

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      btns       <= DIR_NONE;
      move_valid <= 1'b0;
      dir_held   <= DIR_NONE;
`ifdef BTN_AUTO_REPEAT_EN
      cnt        <= '0;
`endif
    end else begin
      btns       <= DIR_NONE;
      move_valid <= 1'b0;
      if (state == IDLE) begin
        if (|deb) begin
          state      <= PRESS;
          dir_held   <= winner;
          btns       <= winner;
          move_valid <= 1'b1;
        end
      end else if (!held_pressed) begin
        // Release beats any repeat due this edge; winner is DIR_NONE if nothing else is pressed.
        dir_held <= winner;
        if (|deb) begin
          state      <= PRESS;
          btns       <= winner;
          move_valid <= 1'b1;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
`ifdef BTN_AUTO_REPEAT_EN
          PRESS: begin
            state <= DELAY;
            cnt   <= DELAY_LOAD;
          end
          DELAY: begin
            if (cnt == '0) begin
              state      <= REPEAT;
              btns       <= dir_held;
              move_valid <= 1'b1;
              cnt        <= RATE_LOAD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          REPEAT: begin
            if (cnt == '0) begin
              btns       <= dir_held;
              move_valid <= 1'b1;
              cnt        <= RATE_LOAD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
`else
          PRESS: state <= HOLD;
          HOLD:  state <= HOLD;
`endif
          default: begin
            state    <= IDLE;
            dir_held <= DIR_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_move_encoder.sv
// Scoreboard bench for btn_move_encoder; expectations follow BTN_AUTO_REPEAT_EN when defined.
module tb_btn_move_encoder;
  import btn_pkg::*;

  localparam int LAT = 7;  // drive at negedge after edge c0 -> pulse seen after edge c0+7

  logic       btnClk;
  logic       rst;
  logic [3:0] btns_raw;
  logic [3:0] btns;
  logic       move_valid;
  logic [3:0] dir_held;

  btn_move_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (3)
  ) dut (
    .btnClk    (btnClk),
    .rst       (rst),
    .btns_raw  (btns_raw),
    .btns      (btns),
    .move_valid(move_valid),
    .dir_held  (dir_held)
  );

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial begin
    btnClk = 1'b0;
    forever #5 btnClk = ~btnClk;
  end

  always @(posedge btnClk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [3:0] code);
    sb.push_back('{at, code});
  endtask

  task automatic expect_repeats(input int first, input int last, input logic [3:0] code);
    for (int t = first; t <= last; t += 3) expect_pulse(t, code);
  endtask

  task automatic go_to(input int t);
    while (cyc < t) @(negedge btnClk);
  endtask

  // Monitor: every presented move code is matched against the scoreboard head.
  always @(negedge btnClk) begin
    exp_t e;
    check("valid_matches_btns", {31'd0, move_valid}, {31'd0, |btns});
    if (move_valid || btns != DIR_NONE) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, btns}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_code", {28'd0, btns}, {28'd0, e.code});
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("pulse_missing_at", cyc, e.cyc);
    end
  end

  initial begin
    int c0;
    int c1;
    rst      = 1'b1;
    btns_raw = 4'd0;
    repeat (3) @(negedge btnClk);
    check("reset_btns", {28'd0, btns}, 32'd0);
    check("reset_valid", {31'd0, move_valid}, 32'd0);
    check("reset_dir_held", {28'd0, dir_held}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge btnClk);

    // 1: U held for 30 cycles
    c0 = cyc;
    btns_raw = DIR_U;
    expect_pulse(c0 + LAT, DIR_U);
`ifdef BTN_AUTO_REPEAT_EN
    expect_repeats(c0 + 15, c0 + 36, DIR_U);
`endif
    go_to(c0 + 10);
    check("s1_dir_held", {28'd0, dir_held}, {28'd0, DIR_U});
    go_to(c0 + 30);
    btns_raw = 4'd0;
    go_to(c0 + 45);
    check("s1_released", {28'd0, dir_held}, 32'd0);
    go_to(c0 + 50);

    // 2: three-sample glitch on R is filtered
    c0 = cyc;
    btns_raw = DIR_R;
    go_to(c0 + 3);
    btns_raw = 4'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge btnClk);
      check("s2_dir_held", {28'd0, dir_held}, 32'd0);
    end
    go_to(c0 + 20);

    // 3: L owns, U ignored; releasing L hands over to U
    c0 = cyc;
    btns_raw = DIR_L;
    expect_pulse(c0 + LAT, DIR_L);
`ifdef BTN_AUTO_REPEAT_EN
    expect_repeats(c0 + 15, c0 + 24, DIR_L);
`endif
    expect_pulse(c0 + 27, DIR_U);
`ifdef BTN_AUTO_REPEAT_EN
    expect_repeats(c0 + 35, c0 + 44, DIR_U);
`endif
    go_to(c0 + 10);
    btns_raw = DIR_L | DIR_U;
    go_to(c0 + 20);
    check("s3_sticky_l", {28'd0, dir_held}, {28'd0, DIR_L});
    btns_raw = DIR_U;
    go_to(c0 + 30);
    check("s3_handover_u", {28'd0, dir_held}, {28'd0, DIR_U});
    go_to(c0 + 40);
    btns_raw = 4'd0;
    go_to(c0 + 60);

    // 4: U and D together -> U wins; release beats the repeat due at +18
    c0 = cyc;
    btns_raw = DIR_U | DIR_D;
    expect_pulse(c0 + LAT, DIR_U);
`ifdef BTN_AUTO_REPEAT_EN
    expect_pulse(c0 + 15, DIR_U);
`endif
    go_to(c0 + 9);
    check("s4_dir_held", {28'd0, dir_held}, {28'd0, DIR_U});
    go_to(c0 + 11);
    btns_raw = 4'd0;
    go_to(c0 + 30);
    check("s4_released", {28'd0, dir_held}, 32'd0);

    // 5: reset while U is held and owned
    c0 = cyc;
    btns_raw = DIR_U;
    expect_pulse(c0 + LAT, DIR_U);
`ifdef BTN_AUTO_REPEAT_EN
    expect_pulse(c0 + 15, DIR_U);
    expect_pulse(c0 + 18, DIR_U);
`endif
    go_to(c0 + 20);
    check("s5_pre_reset_held", {28'd0, dir_held}, {28'd0, DIR_U});
    rst = 1'b1;
    #1;
    check("s5_rst_btns", {28'd0, btns}, 32'd0);
    check("s5_rst_valid", {31'd0, move_valid}, 32'd0);
    check("s5_rst_dir_held", {28'd0, dir_held}, 32'd0);
    go_to(c0 + 23);
    rst = 1'b0;
    expect_pulse(c0 + 30, DIR_U);
`ifdef BTN_AUTO_REPEAT_EN
    expect_pulse(c0 + 38, DIR_U);
    expect_pulse(c0 + 41, DIR_U);
`endif
    go_to(c0 + 36);
    btns_raw = 4'd0;
    go_to(c0 + 55);

    // 6: long D hold, then release and re-press
    c0 = cyc;
    btns_raw = DIR_D;
    expect_pulse(c0 + LAT, DIR_D);
`ifdef BTN_AUTO_REPEAT_EN
    expect_repeats(c0 + 15, c0 + 45, DIR_D);
`endif
    go_to(c0 + 40);
    btns_raw = 4'd0;
    go_to(c0 + 60);
    c1 = cyc;
    btns_raw = DIR_D;
    expect_pulse(c1 + LAT, DIR_D);
`ifdef BTN_AUTO_REPEAT_EN
    expect_pulse(c1 + 15, DIR_D);
`endif
    go_to(c1 + 10);
    btns_raw = 4'd0;
    go_to(c1 + 30);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
